// File: rtl/div_sched.sv
// div_sched: multi-cycle divide scheduler for the EX stage.
// Accepts one div.w/div.wu/mod.w/mod.wu request at a time. The latched
// operands are steered to the signed or unsigned divider IP over
// AXI-Stream, and the quotient or remainder is captured. The result is
// held until EX consumes it. A flush while the IP is busy drains the IP
// and drops the result.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer a zero divisor
// locally (IDLE->HOLD) without touching either IP.

module div_sched (
  input  logic        clk,
  input  logic        resetn,
  // request side (EX)
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_src1,
  input  logic [31:0] i_req_src2,
  input  logic        i_flush,
  output logic        o_busy,
  // response side (EX)
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_result,
  // operand streams, shared data for both IPs
  output logic [31:0] o_dvd_tdata,
  output logic [31:0] o_dvs_tdata,
  // signed IP
  output logic        o_s_dvd_tvalid,
  output logic        o_s_dvs_tvalid,
  input  logic        i_s_dvd_tready,
  input  logic        i_s_dvs_tready,
  // unsigned IP
  output logic        o_u_dvd_tvalid,
  output logic        o_u_dvs_tvalid,
  input  logic        i_u_dvd_tready,
  input  logic        i_u_dvs_tready,
  // IP results: {quotient, remainder}, no back-pressure
  input  logic        i_s_out_tvalid,
  input  logic        i_u_out_tvalid,
  input  logic [63:0] i_s_out_tdata,
  input  logic [63:0] i_u_out_tdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sel_signed;
  logic        r_sel_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic        r_dvd_sent;
  logic        r_dvs_sent;
  logic        r_discard;
  logic [31:0] r_resp_result;

  logic        w_accept;
  logic        w_req_signed;
  logic        w_req_rem;
  logic        w_dvd_tvalid;
  logic        w_dvs_tvalid;
  logic        w_dvd_tready;
  logic        w_dvs_tready;
  logic        w_dvd_fire;
  logic        w_dvs_fire;
  logic        w_dvd_done;
  logic        w_dvs_done;
  logic        w_out_tvalid;
  logic [63:0] w_out_tdata;
  logic [31:0] w_out_pick;
  logic        w_drop;

  // Request side handshake and op decode. Decode only ever sends a
  // one-hot op, so "signed" can equally be written as "not an unsigned
  // op"; the combined form keeps every op bit meaningful.
  assign o_req_ready  = (r_state == ST_IDLE) & ~i_flush;
  assign w_accept     = i_req_valid & o_req_ready;
  assign w_req_signed = (i_req_op[0] | i_req_op[2]) & ~(i_req_op[1] | i_req_op[3]);
  assign w_req_rem    = i_req_op[2] | i_req_op[3];

  // Operand channels: each channel keeps tvalid up until its own
  // handshake, independent of the other channel and of flush.
  assign w_dvd_tvalid = (r_state == ST_ISSUE) & ~r_dvd_sent;
  assign w_dvs_tvalid = (r_state == ST_ISSUE) & ~r_dvs_sent;
  assign w_dvd_tready = r_sel_signed ? i_s_dvd_tready : i_u_dvd_tready;
  assign w_dvs_tready = r_sel_signed ? i_s_dvs_tready : i_u_dvs_tready;
  assign w_dvd_fire   = w_dvd_tvalid & w_dvd_tready;
  assign w_dvs_fire   = w_dvs_tvalid & w_dvs_tready;
  assign w_dvd_done   = r_dvd_sent | w_dvd_fire;
  assign w_dvs_done   = r_dvs_sent | w_dvs_fire;

  assign o_s_dvd_tvalid = w_dvd_tvalid & r_sel_signed;
  assign o_s_dvs_tvalid = w_dvs_tvalid & r_sel_signed;
  assign o_u_dvd_tvalid = w_dvd_tvalid & ~r_sel_signed;
  assign o_u_dvs_tvalid = w_dvs_tvalid & ~r_sel_signed;
  assign o_dvd_tdata    = r_dvd;
  assign o_dvs_tdata    = r_dvs;

  // Result side: only the selected IP is listened to.
  assign w_out_tvalid = r_sel_signed ? i_s_out_tvalid : i_u_out_tvalid;
  assign w_out_tdata  = r_sel_signed ? i_s_out_tdata  : i_u_out_tdata;
  assign w_out_pick   = r_sel_rem ? w_out_tdata[31:0] : w_out_tdata[63:32];
  // A flush arriving in the same cycle as the result still cancels it.
  assign w_drop       = r_discard | i_flush;

  assign o_busy        = (r_state != ST_IDLE);
  assign o_resp_valid  = (r_state == ST_HOLD);
  assign o_resp_result = r_resp_result;

  // Scheduler FSM: latches the request, drives the issue handshakes,
  // captures the IP result and holds it until EX takes it or flushes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_sel_signed  <= 1'b0;
      r_sel_rem     <= 1'b0;
      r_dvd         <= 32'd0;
      r_dvs         <= 32'd0;
      r_dvd_sent    <= 1'b0;
      r_dvs_sent    <= 1'b0;
      r_discard     <= 1'b0;
      r_resp_result <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel_signed <= w_req_signed;
            r_sel_rem    <= w_req_rem;
            r_dvd        <= i_req_src1;
            r_dvs        <= i_req_src2;
            r_dvd_sent   <= 1'b0;
            r_dvs_sent   <= 1'b0;
            r_discard    <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            if (i_req_src2 == 32'd0) begin
              r_resp_result <= w_req_rem ? i_req_src1 : 32'hFFFF_FFFF;
              r_state       <= ST_HOLD;
            end else begin
              r_state       <= ST_ISSUE;
            end
`else
            r_state      <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: begin
          if (w_dvd_fire) begin
            r_dvd_sent <= 1'b1;
          end
          if (w_dvs_fire) begin
            r_dvs_sent <= 1'b1;
          end
          if (i_flush) begin
            r_discard <= 1'b1;
          end
          if (w_dvd_done && w_dvs_done) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_flush) begin
            r_discard <= 1'b1;
          end
          if (w_out_tvalid) begin
            r_resp_result <= w_out_pick;
            r_state       <= w_drop ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_resp_ready || i_flush) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed, table-driven bench for div_sched.
// Contains a small behavioural model of the signed and unsigned divider
// IPs (configurable latency and divisor-channel back-pressure). The model
// also pulses the unselected IP's result valid with junk data to show that
// the scheduler ignores it.
// Build with or without DIV_ZERO_BYPASS_EN; the zero-divisor checks adapt.

module tb_div_sched;

  localparam logic [3:0] OP_DIV_W  = 4'b0001;
  localparam logic [3:0] OP_DIV_WU = 4'b0010;
  localparam logic [3:0] OP_MOD_W  = 4'b0100;
  localparam logic [3:0] OP_MOD_WU = 4'b1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        reqValid;
  logic        reqReady;
  logic [3:0]  reqOp;
  logic [31:0] reqSrc1;
  logic [31:0] reqSrc2;
  logic        flush;
  logic        busy;
  logic        respValid;
  logic        respReady;
  logic [31:0] respResult;
  logic [31:0] dvdTdata;
  logic [31:0] dvsTdata;
  logic        sDvdTvalid, sDvsTvalid, sDvdTready, sDvsTready;
  logic        uDvdTvalid, uDvsTvalid, uDvdTready, uDvsTready;
  logic        sOutTvalid, uOutTvalid;
  logic [63:0] sOutTdata, uOutTdata;

  div_sched dut (
    .clk            (clk),
    .resetn         (resetn),
    .i_req_valid    (reqValid),
    .o_req_ready    (reqReady),
    .i_req_op       (reqOp),
    .i_req_src1     (reqSrc1),
    .i_req_src2     (reqSrc2),
    .i_flush        (flush),
    .o_busy         (busy),
    .o_resp_valid   (respValid),
    .i_resp_ready   (respReady),
    .o_resp_result  (respResult),
    .o_dvd_tdata    (dvdTdata),
    .o_dvs_tdata    (dvsTdata),
    .o_s_dvd_tvalid (sDvdTvalid),
    .o_s_dvs_tvalid (sDvsTvalid),
    .i_s_dvd_tready (sDvdTready),
    .i_s_dvs_tready (sDvsTready),
    .o_u_dvd_tvalid (uDvdTvalid),
    .o_u_dvs_tvalid (uDvsTvalid),
    .i_u_dvd_tready (uDvdTready),
    .i_u_dvs_tready (uDvsTready),
    .i_s_out_tvalid (sOutTvalid),
    .i_u_out_tvalid (uOutTvalid),
    .i_s_out_tdata  (sOutTdata),
    .i_u_out_tdata  (uOutTdata)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int numChecks = 0;
  int numFails  = 0;

  // Divider IP model state.
  bit          gotDvd, gotDvs, mSigned, pending;
  logic [31:0] mDvd, mDvs;
  int          cnt;
  int          ipLat;
  int          dvsHold;
  int          cntSDvd, cntSDvs, cntUDvd, cntUDvs;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] expResult;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic of the divider IPs: {quotient, remainder}.
  function automatic logic [63:0] ipCalc(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {q, r};
    end
    return {a / b, a % b};
  endfunction

  // One clock cycle: sample handshakes before the edge, then advance the
  // IP model and drive its outputs shortly after the edge.
  task automatic tick();
    logic        fDvd, fDvs, selS;
    logic [31:0] a, b;
    fDvd = (sDvdTvalid & sDvdTready) | (uDvdTvalid & uDvdTready);
    fDvs = (sDvsTvalid & sDvsTready) | (uDvsTvalid & uDvsTready);
    selS = sDvdTvalid | sDvsTvalid;
    a    = dvdTdata;
    b    = dvsTdata;
    if (sDvdTvalid) cntSDvd++;
    if (sDvsTvalid) cntSDvs++;
    if (uDvdTvalid) cntUDvd++;
    if (uDvsTvalid) cntUDvs++;
    @(posedge clk);
    #1;
    sOutTvalid = 1'b0;
    uOutTvalid = 1'b0;
    if (!resetn) begin
      gotDvd  = 1'b0;
      gotDvs  = 1'b0;
      pending = 1'b0;
    end else begin
      if (fDvd) begin gotDvd = 1'b1; mDvd = a; mSigned = selS; end
      if (fDvs) begin gotDvs = 1'b1; mDvs = b; mSigned = selS; end
      if (gotDvd && !gotDvs && dvsHold > 0) dvsHold--;
      if (gotDvd && gotDvs && !pending) begin
        pending = 1'b1;
        cnt     = ipLat;
      end
      if (pending) begin
        if (cnt == 0) begin
          if (mSigned) begin
            sOutTvalid = 1'b1;
            sOutTdata  = ipCalc(1'b1, mDvd, mDvs);
          end else begin
            uOutTvalid = 1'b1;
            uOutTdata  = ipCalc(1'b0, mDvd, mDvs);
          end
          pending = 1'b0;
          gotDvd  = 1'b0;
          gotDvs  = 1'b0;
        end else begin
          cnt--;
          if (cnt == 0) begin
            if (mSigned) begin
              uOutTvalid = 1'b1;
              uOutTdata  = 64'hDEAD_BEEF_CAFE_F00D;
            end else begin
              sOutTvalid = 1'b1;
              sOutTdata  = 64'hDEAD_BEEF_CAFE_F00D;
            end
          end
        end
      end
    end
    sDvsTready = (dvsHold == 0);
    uDvsTready = (dvsHold == 0);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    reqValid = valid;
    reqOp    = op;
    reqSrc1  = a;
    reqSrc2  = b;
  endtask

  task automatic clearCounts();
    cntSDvd = 0;
    cntSDvs = 0;
    cntUDvd = 0;
    cntUDvs = 0;
  endtask

  // Present a request for one cycle; leaves the bench in cycle accept+1.
  task automatic startReq(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    clearCounts();
    applyStimulus(1'b1, op, a, b);
    #1;
    checkOutput({name, "_req_ready"}, {31'd0, reqReady}, 32'd1);
    tick();
    applyStimulus(1'b0, op, a, b);
    #1;
  endtask

  // Wait (bounded) for resp_valid; n is the cycle count since accept.
  task automatic waitResp(input string name, output int n);
    n = 1;
    while (!respValid && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, "_resp_valid"}, {31'd0, respValid}, 32'd1);
  endtask

  task automatic finishResp(input string name);
    respReady = 1'b1;
    #1;
    tick();
    respReady = 1'b0;
    #1;
    checkOutput({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_idle_ready"}, {31'd0, reqReady}, 32'd1);
  endtask

  task automatic doTxn(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] exp);
    int n;
    ipLat   = lat;
    dvsHold = 0;
    startReq(name, op, a, b);
    waitResp(name, n);
    checkOutput({name, "_result"}, respResult, exp);
    checkOutput({name, "_latency"}, n, 3 + lat);
    finishResp(name);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int n;
    int outAt;
    bit sawResp;

    vecs[0] = '{OP_DIV_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1};
    vecs[1] = '{OP_MOD_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0};
    vecs[2] = '{OP_DIV_WU, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 3};
    vecs[3] = '{OP_MOD_WU, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 2};
    vecs[4] = '{OP_DIV_W,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFE, 1};
    vecs[5] = '{OP_MOD_W,  32'd7,         32'hFFFF_FFFD, 32'h0000_0001, 5};
    vecs[6] = '{OP_DIV_WU, 32'd100,       32'd7,         32'd14,        0};
    vecs[7] = '{OP_MOD_WU, 32'd1000,      32'd7,         32'd6,         4};
    vecs[8] = '{OP_DIV_W,  32'h8000_0000, 32'd2,         32'hC000_0000, 2};

    resetn     = 1'b0;
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0);
    flush      = 1'b0;
    respReady  = 1'b0;
    sDvdTready = 1'b1;
    uDvdTready = 1'b1;
    sDvsTready = 1'b1;
    uDvsTready = 1'b1;
    sOutTvalid = 1'b0;
    uOutTvalid = 1'b0;
    sOutTdata  = 64'd0;
    uOutTdata  = 64'd0;
    gotDvd = 1'b0; gotDvs = 1'b0; pending = 1'b0; mSigned = 1'b0;
    mDvd = 32'd0; mDvs = 32'd0; cnt = 0; ipLat = 0; dvsHold = 0;
    clearCounts();

    $display("[TB] reset");
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_resp_valid", {31'd0, respValid}, 32'd0);
    checkOutput("reset_resp_result", respResult, 32'd0);
    checkOutput("reset_req_ready", {31'd0, reqReady}, 32'd1);
    checkOutput("reset_tvalids", {28'd0, sDvdTvalid, sDvsTvalid, uDvdTvalid, uDvsTvalid}, 32'd0);
    resetn = 1'b1;
    tick();

    $display("[TB] div.w -7/2, IP latency 8");
    ipLat = 8;
    dvsHold = 0;
    startReq("divw_lat8", OP_DIV_W, 32'hFFFF_FFF9, 32'd2);
    waitResp("divw_lat8", n);
    checkOutput("divw_lat8_cycles", n, 32'd11);
    checkOutput("divw_lat8_result", respResult, 32'hFFFF_FFFD);
    checkOutput("divw_lat8_s_dvd_cycles", cntSDvd, 32'd1);
    checkOutput("divw_lat8_s_dvs_cycles", cntSDvs, 32'd1);
    checkOutput("divw_lat8_u_valids", cntUDvd + cntUDvs, 32'd0);
    finishResp("divw_lat8");

    $display("[TB] mod.wu with delayed divisor tready");
    ipLat = 2;
    dvsHold = 3;
    startReq("modwu_dly", OP_MOD_WU, 32'hFFFF_FFF9, 32'd2);
    checkOutput("modwu_dly_dvd_first", {31'd0, uDvdTvalid}, 32'd1);
    checkOutput("modwu_dly_dvs_first", {31'd0, uDvsTvalid}, 32'd1);
    tick();
    checkOutput("modwu_dly_dvd_dropped", {31'd0, uDvdTvalid}, 32'd0);
    checkOutput("modwu_dly_dvs_held", {31'd0, uDvsTvalid}, 32'd1);
    waitResp("modwu_dly", n);
    checkOutput("modwu_dly_result", respResult, 32'd1);
    checkOutput("modwu_dly_u_dvs_cycles", cntUDvs, 32'd4);
    checkOutput("modwu_dly_s_valids", cntSDvd + cntSDvs, 32'd0);
    finishResp("modwu_dly");

    $display("[TB] div.wu 100/7 with resp_ready held low");
    ipLat = 3;
    dvsHold = 0;
    startReq("hold", OP_DIV_WU, 32'd100, 32'd7);
    waitResp("hold", n);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_resp_valid", {31'd0, respValid}, 32'd1);
      checkOutput("hold_resp_result", respResult, 32'd14);
      checkOutput("hold_req_ready", {31'd0, reqReady}, 32'd0);
      tick();
    end
    finishResp("hold");

    $display("[TB] mod.w 17/5 flushed during WAIT");
    ipLat = 4;
    dvsHold = 0;
    startReq("flush_wait", OP_MOD_W, 32'd17, 32'd5);
    tick();
    tick();
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    #1;
    n = 4;
    outAt = -1;
    sawResp = 1'b0;
    while (busy && n < 100) begin
      if (respValid) sawResp = 1'b1;
      if (sOutTvalid) outAt = n;
      tick();
      n++;
    end
    checkOutput("flush_wait_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_wait_no_resp", {31'd0, sawResp}, 32'd0);
    checkOutput("flush_wait_drop_cycle", n, 32'd7);
    checkOutput("flush_wait_drop_after_out", n, outAt + 1);
    doTxn("after_flush", OP_DIV_W, 32'd9, 32'd3, 2, 32'd3);

    $display("[TB] flush during ISSUE with divisor still pending");
    ipLat = 2;
    dvsHold = 3;
    startReq("flush_issue", OP_MOD_WU, 32'd5, 32'd2);
    tick();
    flush = 1'b1;
    #1;
    checkOutput("flush_issue_dvs_valid", {31'd0, uDvsTvalid}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_issue_dvs_still_valid", {31'd0, uDvsTvalid}, 32'd1);
    checkOutput("flush_issue_dvs_data", dvsTdata, 32'd2);
    n = 0;
    sawResp = 1'b0;
    while (busy && n < 100) begin
      if (respValid) sawResp = 1'b1;
      tick();
      n++;
    end
    checkOutput("flush_issue_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_issue_no_resp", {31'd0, sawResp}, 32'd0);
    checkOutput("flush_issue_u_dvd_cycles", cntUDvd, 32'd1);

    $display("[TB] flush in HOLD");
    ipLat = 1;
    dvsHold = 0;
    startReq("flush_hold", OP_MOD_W, 32'd17, 32'd5);
    waitResp("flush_hold", n);
    checkOutput("flush_hold_result", respResult, 32'd2);
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_hold_resp_valid", {31'd0, respValid}, 32'd0);
    checkOutput("flush_hold_busy", {31'd0, busy}, 32'd0);

    $display("[TB] flush together with req_valid in IDLE");
    ipLat = 2;
    dvsHold = 0;
    clearCounts();
    applyStimulus(1'b1, OP_DIV_W, 32'd9, 32'd3);
    flush = 1'b1;
    #1;
    checkOutput("idle_flush_ready", {31'd0, reqReady}, 32'd0);
    tick();
    checkOutput("idle_flush_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("idle_flush_tvalids", {28'd0, sDvdTvalid, sDvsTvalid, uDvdTvalid, uDvsTvalid}, 32'd0);
    flush = 1'b0;
    #1;
    checkOutput("idle_unflush_ready", {31'd0, reqReady}, 32'd1);
    tick();
    applyStimulus(1'b0, OP_DIV_W, 32'd9, 32'd3);
    #1;
    checkOutput("idle_unflush_busy", {31'd0, busy}, 32'd1);
    waitResp("idle_unflush", n);
    checkOutput("idle_unflush_result", respResult, 32'd3);
    finishResp("idle_unflush");

    $display("[TB] reset in the middle of an operation");
    ipLat = 8;
    dvsHold = 0;
    startReq("mid_reset", OP_DIV_WU, 32'd100, 32'd7);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_reset_resp_valid", {31'd0, respValid}, 32'd0);
    checkOutput("mid_reset_result", respResult, 32'd0);
    checkOutput("mid_reset_tvalids", {28'd0, sDvdTvalid, sDvsTvalid, uDvdTvalid, uDvsTvalid}, 32'd0);
    resetn = 1'b1;
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      doTxn($sformatf("vec%0d", i), vecs[i].op, vecs[i].src1, vecs[i].src2, vecs[i].lat, vecs[i].expResult);
    end

    $display("[TB] zero divisor");
    ipLat = 2;
    dvsHold = 0;
    startReq("zero_divw", OP_DIV_W, 32'd5, 32'd0);
    waitResp("zero_divw", n);
    checkOutput("zero_divw_result", respResult, 32'hFFFF_FFFF);
`ifdef DIV_ZERO_BYPASS_EN
    checkOutput("zero_divw_cycles", n, 32'd1);
    checkOutput("zero_divw_ip_valids", cntSDvd + cntSDvs + cntUDvd + cntUDvs, 32'd0);
`else
    checkOutput("zero_divw_cycles", n, 32'd5);
    checkOutput("zero_divw_s_dvd_cycles", cntSDvd, 32'd1);
`endif
    finishResp("zero_divw");
    startReq("zero_modwu", OP_MOD_WU, 32'd5, 32'd0);
    waitResp("zero_modwu", n);
    checkOutput("zero_modwu_result", respResult, 32'd5);
`ifdef DIV_ZERO_BYPASS_EN
    checkOutput("zero_modwu_cycles", n, 32'd1);
    checkOutput("zero_modwu_ip_valids", cntSDvd + cntSDvs + cntUDvd + cntUDvs, 32'd0);
`else
    checkOutput("zero_modwu_cycles", n, 32'd5);
    checkOutput("zero_modwu_u_dvd_cycles", cntUDvd, 32'd1);
`endif
    finishResp("zero_modwu");

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
